// File: rtl/vx_scoreboard_pkg.sv
// vx_scoreboard_pkg: shared widths, width helpers and issue/writeback record types for the scoreboard.
package vx_scoreboard_pkg;
    localparam int NUM_WARPS_DEF = 4;
    localparam int NUM_REGS_DEF  = 64;
    localparam int PAYLOAD_W_DEF = 128;

    function automatic int wid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int nr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WID_W = wid_w(NUM_WARPS_DEF);
    localparam int NR_W  = nr_w(NUM_REGS_DEF);

    typedef struct packed {
        logic [WID_W-1:0]         wid;
        logic                     wb;
        logic [NR_W-1:0]          rd;
        logic [NR_W-1:0]          rs1;
        logic [NR_W-1:0]          rs2;
        logic [NR_W-1:0]          rs3;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } sb_instr_t;

    typedef struct packed {
        logic [WID_W-1:0] wid;
        logic [NR_W-1:0]  rd;
        logic             eop;
    } sb_wb_t;
endpackage

// File: rtl/vx_sb_pipe_reg.sv
// vx_sb_pipe_reg: single-entry valid/ready pipeline register; holds its data while the consumer stalls.
module vx_sb_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/vx_scoreboard.sv
// vx_scoreboard: per-warp in-flight register tracking; blocks RAW/WAW hazards and registers clean issues.
module vx_scoreboard
    import vx_scoreboard_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 64,
    parameter int PAYLOAD_W   = 128,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [wid_w(NUM_WARPS)-1:0]  in_wid,
    input  logic                         in_wb,
    input  logic [nr_w(NUM_REGS)-1:0]    in_rd,
    input  logic [nr_w(NUM_REGS)-1:0]    in_rs1,
    input  logic [nr_w(NUM_REGS)-1:0]    in_rs2,
    input  logic [nr_w(NUM_REGS)-1:0]    in_rs3,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [wid_w(NUM_WARPS)-1:0]  out_wid,
    output logic                         out_wb,
    output logic [nr_w(NUM_REGS)-1:0]    out_rd,
    output logic [nr_w(NUM_REGS)-1:0]    out_rs1,
    output logic [nr_w(NUM_REGS)-1:0]    out_rs2,
    output logic [nr_w(NUM_REGS)-1:0]    out_rs3,
    output logic [PAYLOAD_W-1:0]         out_payload,
    input  logic                         out_ready,
    input  logic                         wb_valid,
    input  logic [wid_w(NUM_WARPS)-1:0]  wb_wid,
    input  logic [nr_w(NUM_REGS)-1:0]    wb_rd,
    input  logic                         wb_eop,
    output logic                         stall_timeout,
    output logic                         inuse_any
);
    localparam int W_ID = wid_w(NUM_WARPS);
    localparam int W_R  = nr_w(NUM_REGS);
    localparam int DW   = W_ID + 1 + 4 * W_R + PAYLOAD_W;
    localparam int CW   = $clog2(STALL_LIMIT + 1);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               timeout_q;
    logic                               hazard, stage_free, fire, stalled;
    logic [DW-1:0]                      out_data;

    // No writeback bypass: hazard looks only at registered state.
    assign hazard = inuse_q[in_wid][in_rs1] | inuse_q[in_wid][in_rs2] | inuse_q[in_wid][in_rs3]
                  | (in_wb & inuse_q[in_wid][in_rd]);
    assign in_ready = ~hazard & stage_free;
    assign fire     = in_valid & in_ready;
    assign stalled  = in_valid & ~in_ready;

    vx_sb_pipe_reg #(.W(DW)) u_out (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid & ~hazard),
        .in_ready_o  (stage_free),
        .in_data_i   ({in_wid, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_payload}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    assign {out_wid, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_payload} = out_data;

    // Clear first so a coincident set on the same bit wins.
    always_comb begin
        inuse_d = inuse_q;
        if (wb_valid && wb_eop && wb_rd != '0) inuse_d[wb_wid][wb_rd] = 1'b0;
        if (fire && in_wb && in_rd != '0) inuse_d[in_wid][in_rd] = 1'b1;
    end

    assign cnt_d = stalled ? ((cnt_q == CW'(STALL_LIMIT)) ? cnt_q : cnt_q + CW'(1)) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            inuse_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            inuse_q   <= inuse_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | (cnt_d == CW'(STALL_LIMIT));
        end
    end

    assign stall_timeout = timeout_q;
    assign inuse_any     = |inuse_q;
endmodule

// File: tb/tb_vx_scoreboard.sv
// tb_vx_scoreboard: directed scenarios plus randomized traffic checked against a per-warp register-set model.
module tb_vx_scoreboard;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_wb, in_ready, out_valid, out_wb, out_ready;
    logic [1:0]   in_wid, out_wid, wb_wid;
    logic [5:0]   in_rd, in_rs1, in_rs2, in_rs3, out_rd, out_rs1, out_rs2, out_rs3, wb_rd;
    logic [127:0] in_payload, out_payload;
    logic         wb_valid, wb_eop, stall_timeout, inuse_any;
    logic [154:0] dut_out;

    bit           minuse [4][64];
    bit           mv, mto;
    int           mcnt;
    logic [154:0] mout, held;
    int           checks = 0, passes = 0;

    always #5 clk = ~clk;

    vx_scoreboard #(.NUM_WARPS(4), .NUM_REGS(64), .PAYLOAD_W(128), .STALL_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_wid(in_wid), .in_wb(in_wb),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_payload(in_payload),
        .in_ready(in_ready), .out_valid(out_valid), .out_wid(out_wid), .out_wb(out_wb),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_payload(out_payload), .out_ready(out_ready), .wb_valid(wb_valid), .wb_wid(wb_wid),
        .wb_rd(wb_rd), .wb_eop(wb_eop), .stall_timeout(stall_timeout), .inuse_any(inuse_any)
    );

    assign dut_out = {out_wid, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_payload};

    function automatic bit exp_ready();
        bit h = minuse[in_wid][in_rs1] | minuse[in_wid][in_rs2] | minuse[in_wid][in_rs3]
              | (in_wb & minuse[in_wid][in_rd]);
        return !h && (!mv || out_ready);
    endfunction

    function automatic bit m_any();
        bit a = 0;
        foreach (minuse[w, r]) a |= minuse[w][r];
        return a;
    endfunction

    task automatic idle();
        in_valid = 0; in_wb = 0; in_wid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_rs3 = 0;
        wb_valid = 0; wb_eop = 0; wb_wid = 0; wb_rd = 0;
    endtask

    task automatic set_in(input logic [1:0] w, input logic b, input logic [5:0] d, r1, r2, r3);
        in_valid = 1; in_wid = w; in_wb = b; in_rd = d; in_rs1 = r1; in_rs2 = r2; in_rs3 = r3;
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wb_beat(input logic [1:0] w, input logic [5:0] d, input logic e);
        wb_valid = 1; wb_wid = w; wb_rd = d; wb_eop = e;
    endtask

    // Advance one clock and update the model from the inputs presented during the cycle.
    task automatic tick();
        bit rdy, fire, clr;
        rdy  = exp_ready();
        fire = in_valid && rdy;
        clr  = wb_valid && wb_eop && wb_rd != 0;
        if (clr && !minuse[wb_wid][wb_rd]) begin
            checks++;
            $display("FAIL stim_clear_idle w=%0d r=%0d got 0 needs 1", wb_wid, wb_rd);
        end
        if (clr && fire && in_wb && in_wid == wb_wid && in_rd == wb_rd) begin
            checks++;
            $display("FAIL stim_set_clear_same w=%0d r=%0d got 1 needs 0", wb_wid, wb_rd);
        end
        @(posedge clk);
        if (clr) minuse[wb_wid][wb_rd] = 0;
        if (fire && in_wb && in_rd != 0) minuse[in_wid][in_rd] = 1;
        if (fire) begin
            mv = 1;
            mout = {in_wid, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_payload};
        end else if (out_ready) mv = 0;
        mcnt = (in_valid && !rdy) ? ((mcnt < 8) ? mcnt + 1 : 8) : 0;
        if (mcnt == 8) mto = 1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1; idle(); out_ready = 1;
        @(posedge clk);
        foreach (minuse[w, r]) minuse[w][r] = 0;
        mv = 0; mto = 0; mcnt = 0; mout = '0;
        #1 reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b needs 0", out_valid); else passes++;
        checks++; if (dut_out !== '0) $display("FAIL rst_out_data got %h needs 0", dut_out); else passes++;
        checks++; if (inuse_any !== 1'b0) $display("FAIL rst_inuse_any got %b needs 0", inuse_any); else passes++;
        checks++; if (stall_timeout !== 1'b0) $display("FAIL rst_timeout got %b needs 0", stall_timeout); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b needs 1", in_ready); else passes++;
    endtask

    task automatic test_issue();
        set_in(0, 1, 5, 1, 2, 3);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL issue_ready got %b needs 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL issue_out_valid got %b needs 1", out_valid); else passes++;
        checks++; if (dut_out !== mout) $display("FAIL issue_out_data got %h needs %h", dut_out, mout); else passes++;
        checks++; if (inuse_any !== 1'b1) $display("FAIL issue_inuse_any got %b needs 1", inuse_any); else passes++;
    endtask

    task automatic test_raw_release();
        set_in(0, 0, 0, 5, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL raw_block got %b needs 0", in_ready); else passes++;
        wb_beat(0, 5, 1);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL raw_no_bypass got %b needs 0", in_ready); else passes++;
        tick();
        wb_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL raw_release got %b needs 1", in_ready); else passes++;
        tick();
        idle(); tick();
    endtask

    task automatic test_isolation();
        set_in(0, 1, 5, 0, 0, 0); tick();
        set_in(1, 0, 0, 5, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL iso_other_warp got %b needs 1", in_ready); else passes++;
        tick();
        set_in(1, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL iso_r0_untracked got %b needs 1", in_ready); else passes++;
        tick();
        idle(); wb_beat(0, 5, 1); tick();
        idle();
        checks++; if (inuse_any !== 1'b0) $display("FAIL iso_drained got %b needs 0", inuse_any); else passes++;
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        set_in(2, 0, 0, 1, 2, 3); tick();
        held = mout;
        set_in(3, 0, 0, 4, 5, 6);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_%0d got %b needs 0", i, in_ready); else passes++;
            checks++; if (dut_out !== held || out_valid !== 1'b1) $display("FAIL bp_hold_%0d got %b/%h needs 1/%h", i, out_valid, dut_out, held); else passes++;
            tick();
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_resume_ready got %b needs 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_rs1 !== 6'd4) $display("FAIL bp_b2b got %b/%0d/%0d needs 1/3/4", out_valid, out_wid, out_rs1); else passes++;
        idle(); tick();
    endtask

    task automatic test_waw();
        set_in(2, 1, 7, 0, 0, 0); tick();
        set_in(2, 1, 7, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL waw_block got %b needs 0", in_ready); else passes++;
        wb_beat(2, 7, 0); tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL waw_non_eop got %b needs 0", in_ready); else passes++;
        wb_beat(2, 7, 1); tick();
        wb_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL waw_eop_release got %b needs 1", in_ready); else passes++;
        tick();
        idle(); wb_beat(2, 7, 1); tick();
        idle(); tick();
    endtask

    task automatic test_watchdog();
        set_in(3, 1, 9, 0, 0, 0); tick();
        set_in(3, 0, 0, 9, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (stall_timeout !== (i >= 8)) $display("FAIL wd_cycle_%0d got %b needs %b", i, stall_timeout, i >= 8); else passes++;
        end
        idle(); tick(); tick();
        checks++; if (stall_timeout !== 1'b1) $display("FAIL wd_sticky got %b needs 1", stall_timeout); else passes++;
        do_reset();
        #1;
        checks++; if (stall_timeout !== 1'b0 || inuse_any !== 1'b0) $display("FAIL wd_reset got %b/%b needs 0/0", stall_timeout, inuse_any); else passes++;
    endtask

    task automatic test_random();
        int w, r;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0)
                set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                       6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
            else in_valid = 0;
            out_ready = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 3); r = $urandom_range(1, 7);
            wb_valid = 0;
            if ($urandom_range(0, 1) == 1) wb_beat(2'(w), 6'(r), minuse[w][r] && $urandom_range(0, 2) != 0);
            #1;
            checks++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready_%0d got %b needs %b", c, in_ready, exp_ready()); else passes++;
            tick();
            checks++; if (out_valid !== mv || (mv && dut_out !== mout)) $display("FAIL rnd_out_%0d got %b/%h needs %b/%h", c, out_valid, dut_out, mv, mout); else passes++;
            checks++; if (inuse_any !== m_any() || stall_timeout !== mto) $display("FAIL rnd_state_%0d got %b/%b needs %b/%b", c, inuse_any, stall_timeout, m_any(), mto); else passes++;
        end
        idle();
    endtask

    initial begin
        in_payload = '0;
        test_reset();
        test_issue();
        test_raw_release();
        test_isolation();
        test_backpressure();
        test_waw();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
